// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding execute.
// Holds the architectural PC, fetches one 16-bit instruction per commit over
// a req/done handshake, and presents instr_out, pc_out and pc_inc downstream.
// Optional build macro FETCH_ALIGN_CHK_EN: odd PCs trap into a sticky error
// state instead of being silently aligned.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_STEP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_next,
    input  logic        pc_load,
    input  logic        halt,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    output logic [15:0] pc_out,
    output logic [15:0] pc_inc,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_VALID,
        ST_HALT,
        ST_ERR
    } state_t;

    localparam logic [15:0] PC_STEP_W     = 16'(PC_STEP);
    localparam logic [15:0] PC_ALIGN_MASK = 16'hFFFE;

    state_t state;

`ifdef FETCH_ALIGN_CHK_EN
    logic err_q;
    assign err = err_q;
`else
    // Without the alignment check every PC is forced even, so no error exists.
    assign err = 1'b0;
`endif

    // The memory address is always the PC of the instruction being fetched.
    assign imem_addr = pc_out;
    // Sequential successor handed to execute; wraps naturally at 16 bits.
    assign pc_inc    = pc_out + PC_STEP_W;

    // Fetch FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            state       <= ST_IDLE;
            pc_out      <= RESET_PC;
            instr_out   <= 16'h0000;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            halted      <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef FETCH_ALIGN_CHK_EN
                    if (pc_out[0]) begin
                        err_q <= 1'b1;
                        state <= ST_ERR;
                    end else
`endif
                    begin
                        imem_req <= 1'b1;
                        state    <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    // Request and address stay put until memory answers.
                    if (imem_done) begin
                        instr_out   <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_VALID;
                    end
                end

                ST_VALID: begin
                    if (pc_load) begin
                        instr_valid <= 1'b0;
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end
`ifdef FETCH_ALIGN_CHK_EN
                        else if (pc_next[0]) begin
                            // Keep the offending target visible for debug.
                            pc_out <= pc_next;
                            err_q  <= 1'b1;
                            state  <= ST_ERR;
                        end
`endif
                        else begin
                            pc_out   <= pc_next & PC_ALIGN_MASK;
                            imem_req <= 1'b1;
                            state    <= ST_REQ;
                        end
                    end
                end

                // Terminal states: only rst leaves them.
                ST_HALT, ST_ERR: begin
                end

                // NOTE: the 3-bit encoding has unused codes; recover to IDLE
                // rather than lock up if one is ever reached.
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage.
// A transaction-level model tracks the expected PC and instruction; each
// scenario task drives randomized stimulus and compares DUT outputs inline.
module tb_fetch_stage;

    localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef FETCH_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc_next = 16'h0000;
    logic        pc_load = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_done = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [15:0] pc_out;
    logic [15:0] pc_inc;
    logic        halted;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference model: PC of the instruction in flight and its contents.
    logic [15:0] model_pc;
    logic [15:0] model_instr;

    fetch_stage #(.RESET_PC(RESET_PC), .PC_STEP(2)) dut (
        .clk(clk),
        .rst(rst),
        .pc_next(pc_next),
        .pc_load(pc_load),
        .halt(halt),
        .imem_rdata(imem_rdata),
        .imem_done(imem_done),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .instr_out(instr_out),
        .instr_valid(instr_valid),
        .pc_out(pc_out),
        .pc_inc(pc_inc),
        .halted(halted),
        .err(err)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply reset for two edges, check the quiescent state, then release.
    task automatic test_reset();
        rst = 1'b1; pc_load = 1'b0; halt = 1'b0;
        imem_done = 1'b1; imem_rdata = 16'hDEAD;
        tick();
        tick();
        imem_done = 1'b0;
        checks++; if (pc_out !== RESET_PC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_out, RESET_PC); end
        checks++; if (instr_out !== 16'h0000) begin errors++; $display("FAIL reset_instr got=%h exp=0000", instr_out); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
        tick();
        model_pc = RESET_PC;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL first_addr got=%h exp=%h", imem_addr, RESET_PC); end
    endtask

    // Starting in a fresh request: memory answers after `waits` idle cycles.
    // pc_load/halt are toggled randomly while requesting and must be ignored.
    task automatic fetch(input int waits, input logic [15:0] data);
        logic [15:0] exp_inc;
        for (int i = 0; i < waits; i++) begin
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL req_hold got=%b exp=1", imem_req); end
            checks++; if (imem_addr !== model_pc) begin errors++; $display("FAIL addr_hold got=%h exp=%h", imem_addr, model_pc); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL valid_in_req got=%b exp=0", instr_valid); end
            imem_done = 1'b0; imem_rdata = 16'($urandom);
            pc_load = 1'($urandom); halt = 1'($urandom); pc_next = 16'($urandom);
            tick();
        end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL req_done got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== model_pc) begin errors++; $display("FAIL addr_done got=%h exp=%h", imem_addr, model_pc); end
        imem_done = 1'b1; imem_rdata = data;
        pc_load = 1'($urandom); halt = 1'($urandom);
        tick();
        imem_done = 1'b0; pc_load = 1'b0; halt = 1'b0; imem_rdata = 16'($urandom);
        model_instr = data;
        exp_inc = model_pc + 16'd2;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got=%b exp=1", instr_valid); end
        checks++; if (instr_out !== data) begin errors++; $display("FAIL fetch_instr got=%h exp=%h", instr_out, data); end
        checks++; if (pc_out !== model_pc) begin errors++; $display("FAIL fetch_pc got=%h exp=%h", pc_out, model_pc); end
        checks++; if (pc_inc !== exp_inc) begin errors++; $display("FAIL fetch_pc_inc got=%h exp=%h", pc_inc, exp_inc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fetch_req_drop got=%b exp=0", imem_req); end
    endtask

    // Starting in VALID: hold for `waits` cycles, then commit nxt / halt.
    task automatic commit(input int waits, input logic [15:0] nxt, input logic hlt);
        for (int i = 0; i < waits; i++) begin
            pc_load = 1'b0; halt = 1'($urandom); pc_next = 16'($urandom);
            imem_done = 1'($urandom); imem_rdata = 16'($urandom);
            tick();
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got=%b exp=1", instr_valid); end
            checks++; if (instr_out !== model_instr) begin errors++; $display("FAIL hold_instr got=%h exp=%h", instr_out, model_instr); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req got=%b exp=0", imem_req); end
            checks++; if (pc_out !== model_pc) begin errors++; $display("FAIL hold_pc got=%h exp=%h", pc_out, model_pc); end
        end
        imem_done = 1'b0;
        pc_load = 1'b1; pc_next = nxt; halt = hlt;
        tick();
        pc_load = 1'b0; halt = 1'b0;
        if (hlt) begin
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got=%b exp=1", halted); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got=%b exp=0", instr_valid); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req got=%b exp=0", imem_req); end
            checks++; if (pc_out !== model_pc) begin errors++; $display("FAIL halt_pc got=%h exp=%h", pc_out, model_pc); end
        end else if (ALIGN_CHK && nxt[0]) begin
            model_pc = nxt;
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL misalign_err got=%b exp=1", err); end
            checks++; if (pc_out !== nxt) begin errors++; $display("FAIL misalign_pc got=%h exp=%h", pc_out, nxt); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL misalign_req got=%b exp=0", imem_req); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL misalign_valid got=%b exp=0", instr_valid); end
        end else begin
            model_pc = {nxt[15:1], 1'b0};
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL commit_req got=%b exp=1", imem_req); end
            checks++; if (imem_addr !== model_pc) begin errors++; $display("FAIL commit_addr got=%h exp=%h", imem_addr, model_pc); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL commit_valid got=%b exp=0", instr_valid); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL commit_err got=%b exp=0", err); end
        end
    endtask

    task automatic test_zero_wait();
        fetch(0, 16'hC805);
    endtask

    task automatic test_latency();
        commit(2, 16'h0008, 1'b0);
        fetch(2, 16'($urandom));
        commit(0, 16'h0010, 1'b0);
        checks++; if (imem_addr !== 16'h0010) begin errors++; $display("FAIL latency_addr got=%h exp=0010", imem_addr); end
    endtask

    task automatic test_wrap();
        fetch(1, 16'($urandom));
        commit(0, 16'hFFFE, 1'b0);
        fetch(0, 16'($urandom));
        checks++; if (pc_inc !== 16'h0000) begin errors++; $display("FAIL wrap_pc_inc got=%h exp=0000", pc_inc); end
        commit(1, 16'h0000, 1'b0);
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr got=%h exp=0000", imem_addr); end
    endtask

    task automatic test_random();
        logic [15:0] nxt;
        for (int n = 0; n < 25; n++) begin
            fetch(int'($urandom_range(0, 4)), 16'($urandom));
            nxt = 16'($urandom);
            if (ALIGN_CHK) nxt[0] = 1'b0;
            commit(int'($urandom_range(0, 3)), nxt, 1'b0);
        end
    endtask

    task automatic test_misalign();
        fetch(1, 16'($urandom));
        commit(0, 16'h0011, 1'b0);
        if (ALIGN_CHK) begin
            for (int i = 0; i < 5; i++) begin
                imem_done = 1'($urandom); pc_load = 1'($urandom); pc_next = 16'($urandom);
                tick();
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL err_stuck_req got=%b exp=0", imem_req); end
                checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
                checks++; if (pc_out !== 16'h0011) begin errors++; $display("FAIL err_pc got=%h exp=0011", pc_out); end
            end
            imem_done = 1'b0; pc_load = 1'b0;
            test_reset();
        end else begin
            checks++; if (imem_addr !== 16'h0010) begin errors++; $display("FAIL align_addr got=%h exp=0010", imem_addr); end
        end
    endtask

    task automatic test_halt();
        fetch(1, 16'($urandom));
        commit(1, 16'h0040, 1'b1);
        for (int i = 0; i < 20; i++) begin
            imem_done = 1'($urandom); pc_load = 1'($urandom); halt = 1'($urandom); pc_next = 16'($urandom);
            tick();
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halted_req got=%b exp=0", imem_req); end
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_sticky got=%b exp=1", halted); end
            checks++; if (pc_out !== model_pc) begin errors++; $display("FAIL halted_pc got=%h exp=%h", pc_out, model_pc); end
        end
        imem_done = 1'b0; pc_load = 1'b0; halt = 1'b0;
        test_reset();
    endtask

    task automatic test_rst_mid_req();
        imem_done = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL midreq_req got=%b exp=1", imem_req); end
        rst = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midreq_abandon got=%b exp=0", imem_req); end
        rst = 1'b0; imem_done = 1'b1; imem_rdata = 16'hBEEF;
        tick();
        imem_done = 1'b0;
        model_pc = RESET_PC;
        checks++; if (instr_out !== 16'h0000) begin errors++; $display("FAIL midreq_instr got=%h exp=0000", instr_out); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midreq_valid got=%b exp=0", instr_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL midreq_fresh_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL midreq_addr got=%h exp=%h", imem_addr, RESET_PC); end
        fetch(0, 16'($urandom));
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_wrap();
        test_random();
        test_misalign();
        test_halt();
        test_rst_mid_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
